// File: rtl/exec_ctrl_decoder.sv
// rtl/exec_ctrl_decoder.sv - RV32I uop decoder feeding a DEPTH-entry decoded-uop queue
// Decode is combinational at the queue input; head outputs come from queue storage.
module exec_ctrl_decoder #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int ICNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       uop_valid_in,
    output logic                       uop_ready_out,
    input  logic [6:0]                 instruction_type,
    input  logic [2:0]                 funct3,
    input  logic [6:0]                 funct7,
    input  logic [TAG_W-1:0]           uop_tag_in,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [6:0]                 dec_unit_sel,
    output logic [3:0]                 dec_ctrl,
    output logic                       dec_use_imm,
    output logic [TAG_W-1:0]           dec_tag,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [ICNT_W-1:0]          illegal_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = 7 + 4 + 1 + TAG_W;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;

    localparam logic [6:0] F7_Z   = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [6:0] U_ADD = 7'b0000001;
    localparam logic [6:0] U_LOG = 7'b0000010;
    localparam logic [6:0] U_SHF = 7'b0000100;
    localparam logic [6:0] U_BR  = 7'b0001000;
    localparam logic [6:0] U_LD  = 7'b0010000;
    localparam logic [6:0] U_ST  = 7'b0100000;
    localparam logic [6:0] U_ILL = 7'b1000000;

    logic [6:0]       w_sel;
    logic [3:0]       w_ctrl;
    logic             w_imm;
    logic             w_is_i;
    logic             w_f7_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic [ENT_W-1:0] w_head;

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [ICNT_W-1:0] r_icnt;
    logic [ENT_W-1:0] r_mem [DEPTH];

    // For I-forms funct7 is immediate bits, so only shifts constrain it.
    assign w_is_i  = (instruction_type == OP_I);
    assign w_f7_ok = w_is_i || (funct7 == F7_Z);

    always_comb begin
        w_sel  = U_ILL;
        w_ctrl = 4'd0;
        w_imm  = 1'b0;
        case (instruction_type)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000: begin
                        if (w_is_i)                 begin w_sel = U_ADD; w_ctrl = 4'd3; end
                        else if (funct7 == F7_Z)    begin w_sel = U_ADD; w_ctrl = 4'd1; end
                        else if (funct7 == F7_ALT)  begin w_sel = U_ADD; w_ctrl = 4'd2; end
                        else                        w_sel = U_ILL;
                    end
                    3'b010: if (w_f7_ok) begin w_sel = U_ADD; w_ctrl = 4'd4; end
                    3'b011: if (w_f7_ok) begin w_sel = U_ADD; w_ctrl = 4'd5; end
                    3'b100: if (w_f7_ok) begin w_sel = U_LOG; w_ctrl = 4'd2; end
                    3'b110: if (w_f7_ok) begin w_sel = U_LOG; w_ctrl = 4'd1; end
                    3'b111: if (w_f7_ok) begin w_sel = U_LOG; w_ctrl = 4'd3; end
                    3'b001: if (funct7 == F7_Z) begin w_sel = U_SHF; w_ctrl = 4'd1; end
                    default: begin
                        if (funct7 == F7_Z)        begin w_sel = U_SHF; w_ctrl = 4'd2; end
                        else if (funct7 == F7_ALT) begin w_sel = U_SHF; w_ctrl = 4'd3; end
                        else                       w_sel = U_ILL;
                    end
                endcase
                w_imm = w_is_i && !w_sel[6];
            end
            OP_BR: begin
                case (funct3)
                    3'b000:  begin w_sel = U_BR; w_ctrl = 4'd1; end
                    3'b001:  begin w_sel = U_BR; w_ctrl = 4'd2; end
                    3'b100:  begin w_sel = U_BR; w_ctrl = 4'd3; end
                    3'b101:  begin w_sel = U_BR; w_ctrl = 4'd4; end
                    3'b110:  begin w_sel = U_BR; w_ctrl = 4'd5; end
                    3'b111:  begin w_sel = U_BR; w_ctrl = 4'd6; end
                    default: w_sel = U_ILL;
                endcase
            end
            OP_JAL: begin
                w_sel  = U_BR;
                w_ctrl = 4'd7;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    w_sel  = U_BR;
                    w_ctrl = 4'd8;
                    w_imm  = 1'b1;
                end
            end
            OP_LD: begin
                case (funct3)
                    3'b000:  begin w_sel = U_LD; w_ctrl = 4'd1; w_imm = 1'b1; end
                    3'b001:  begin w_sel = U_LD; w_ctrl = 4'd2; w_imm = 1'b1; end
                    3'b010:  begin w_sel = U_LD; w_ctrl = 4'd3; w_imm = 1'b1; end
                    3'b100:  begin w_sel = U_LD; w_ctrl = 4'd4; w_imm = 1'b1; end
                    3'b101:  begin w_sel = U_LD; w_ctrl = 4'd5; w_imm = 1'b1; end
                    default: w_sel = U_ILL;
                endcase
            end
            OP_ST: begin
                case (funct3)
                    3'b000:  begin w_sel = U_ST; w_ctrl = 4'd6; w_imm = 1'b1; end
                    3'b001:  begin w_sel = U_ST; w_ctrl = 4'd7; w_imm = 1'b1; end
                    3'b010:  begin w_sel = U_ST; w_ctrl = 4'd8; w_imm = 1'b1; end
                    default: w_sel = U_ILL;
                endcase
            end
            default: w_sel = U_ILL;
        endcase
    end

    assign w_full        = (r_count == (AW+1)'(DEPTH));
    assign uop_ready_out = !w_full;
    assign dec_valid     = (r_count != '0);
    assign w_push        = uop_valid_in && !w_full;
    assign w_pop         = dec_valid && dec_ready;

    always_ff @(posedge clk) begin
        if (w_push && !reset && !flush) begin
            r_mem[r_wptr] <= {w_sel, w_ctrl, w_imm, uop_tag_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Uops discarded by a same-cycle flush never count as illegal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_icnt <= '0;
        end else if (w_push && !flush && w_sel[6] && !(&r_icnt)) begin
            r_icnt <= r_icnt + 1'b1;
        end
    end

    assign w_head        = r_mem[r_rptr];
    assign dec_unit_sel  = dec_valid ? w_head[ENT_W-1 -: 7]    : 7'd0;
    assign dec_ctrl      = dec_valid ? w_head[TAG_W+4 -: 4]    : 4'd0;
    assign dec_use_imm   = dec_valid ? w_head[TAG_W]           : 1'b0;
    assign dec_tag       = dec_valid ? w_head[TAG_W-1:0]       : '0;
    assign q_count       = r_count;
    assign illegal_count = r_icnt;
endmodule

// File: tb/tb_exec_ctrl_decoder.sv
// tb/tb_exec_ctrl_decoder.sv - scoreboard bench for exec_ctrl_decoder
module tb_exec_ctrl_decoder;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int ICNT_W = 2;
    localparam int ICNT_MAX = (1 << ICNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, flush, uop_valid_in, uop_ready_out;
    logic [6:0]       instruction_type, funct7;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] uop_tag_in, dec_tag;
    logic             dec_valid, dec_ready, dec_use_imm;
    logic [6:0]       dec_unit_sel;
    logic [3:0]       dec_ctrl;
    logic [2:0]       q_count;
    logic [ICNT_W-1:0] illegal_count;

    typedef struct packed {
        logic [6:0]       sel;
        logic [3:0]       ctrl;
        logic             imm;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t sb[$];
    int   m_icnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exec_ctrl_decoder #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ICNT_W(ICNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .uop_valid_in(uop_valid_in), .uop_ready_out(uop_ready_out),
        .instruction_type(instruction_type), .funct3(funct3), .funct7(funct7),
        .uop_tag_in(uop_tag_in), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_unit_sel(dec_unit_sel), .dec_ctrl(dec_ctrl), .dec_use_imm(dec_use_imm),
        .dec_tag(dec_tag), .q_count(q_count), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode: returns {unit_sel, ctrl, use_imm}.
    function automatic logic [11:0] ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int u = 6;
        int c = 0;
        bit imm = 0;
        bit is_r = (op == 7'h33);
        bit is_i = (op == 7'h13);
        bit z = (f7 == 7'h00);
        bit s = (f7 == 7'h20);
        if (is_r || is_i) begin
            if (f3 == 0 && is_i)             begin u = 0; c = 3; end
            else if (f3 == 0 && z)           begin u = 0; c = 1; end
            else if (f3 == 0 && s)           begin u = 0; c = 2; end
            else if (f3 == 2 && (is_i || z)) begin u = 0; c = 4; end
            else if (f3 == 3 && (is_i || z)) begin u = 0; c = 5; end
            else if (f3 == 4 && (is_i || z)) begin u = 1; c = 2; end
            else if (f3 == 6 && (is_i || z)) begin u = 1; c = 1; end
            else if (f3 == 7 && (is_i || z)) begin u = 1; c = 3; end
            else if (f3 == 1 && z)           begin u = 2; c = 1; end
            else if (f3 == 5 && z)           begin u = 2; c = 2; end
            else if (f3 == 5 && s)           begin u = 2; c = 3; end
            imm = is_i && (u != 6);
        end else if (op == 7'h63) begin
            if (f3 != 2 && f3 != 3) begin u = 3; c = (f3 < 2) ? f3 + 1 : f3 - 1; end
        end else if (op == 7'h6F) begin
            u = 3; c = 7;
        end else if (op == 7'h67) begin
            if (f3 == 0) begin u = 3; c = 8; imm = 1; end
        end else if (op == 7'h03) begin
            if (f3 <= 2)                begin u = 4; c = f3 + 1; imm = 1; end
            else if (f3 == 4 || f3 == 5) begin u = 4; c = f3;     imm = 1; end
        end else if (op == 7'h23) begin
            if (f3 <= 2) begin u = 5; c = f3 + 6; imm = 1; end
        end
        return {7'(1 << u), 4'(c), imm};
    endfunction

    task automatic cycle(input logic rst, input logic fl, input logic v, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [TAG_W-1:0] tg,
                         input logic rdy);
        logic [11:0] d;
        ent_t        e;
        bit          do_push, do_pop;
        reset = rst; flush = fl; uop_valid_in = v; instruction_type = op;
        funct3 = f3; funct7 = f7; uop_tag_in = tg; dec_ready = rdy;
        #1;
        check_eq("ready", 32'(uop_ready_out), 32'(sb.size() < DEPTH));
        check_eq("dec_valid", 32'(dec_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check_eq("head_sel", 32'(dec_unit_sel), 32'(sb[0].sel));
            check_eq("head_ctrl", 32'(dec_ctrl), 32'(sb[0].ctrl));
            check_eq("head_imm", 32'(dec_use_imm), 32'(sb[0].imm));
            check_eq("head_tag", 32'(dec_tag), 32'(sb[0].tag));
        end else begin
            check_eq("idle_outs", {13'd0, dec_unit_sel, dec_ctrl, dec_use_imm, dec_tag}, 32'd0);
        end
        do_push = v && (sb.size() < DEPTH);
        do_pop  = rdy && (sb.size() != 0);
        d = ref_dec(op, f3, f7);
        e = '{sel: d[11:5], ctrl: d[4:1], imm: d[0], tag: tg};
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_icnt = 0;
        end else if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                sb.push_back(e);
                if (e.sel[6] && m_icnt < ICNT_MAX) m_icnt++;
            end
        end
        check_eq("q_count", 32'(q_count), 32'(sb.size()));
        check_eq("illegal_count", 32'(illegal_count), 32'(m_icnt));
    endtask

    task automatic push_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [TAG_W-1:0] tg, input logic rdy);
        cycle(1'b0, 1'b0, 1'b1, op, f3, f7, tg, rdy);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, '0, rdy);
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op_r, f7_r;
        ops = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h7F, 7'h37};

        reset = 1'b1; flush = 1'b0; uop_valid_in = 1'b0; dec_ready = 1'b0;
        instruction_type = '0; funct3 = '0; funct7 = '0; uop_tag_in = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 6'd9, 1'b1);
        check_eq("rst_ready", 32'(uop_ready_out), 32'd1);

        // SUB with tag 5
        push_op(7'h33, 3'd0, 7'h20, 6'd5, 1'b0);
        check_eq("sub_sel", 32'(dec_unit_sel), 32'h01);
        check_eq("sub_ctrl", 32'(dec_ctrl), 32'd2);
        check_eq("sub_tag", 32'(dec_tag), 32'd5);
        idle(1'b1);

        // fill, hold off fifth, pop frees a slot only next cycle
        for (int i = 0; i < DEPTH; i++) push_op(7'h33, 3'd0, 7'h00, 6'(10 + i), 1'b0);
        check_eq("full_cnt", 32'(q_count), 32'd4);
        check_eq("full_ready", 32'(uop_ready_out), 32'd0);
        push_op(7'h13, 3'd7, 7'h55, 6'd14, 1'b0);
        push_op(7'h13, 3'd7, 7'h55, 6'd14, 1'b1);
        push_op(7'h13, 3'd7, 7'h55, 6'd14, 1'b0);
        repeat (5) idle(1'b1);

        // illegal load and saturation
        push_op(7'h03, 3'd3, 7'h00, 6'd20, 1'b0);
        check_eq("ill_sel", 32'(dec_unit_sel), 32'h40);
        check_eq("ill_cnt1", 32'(illegal_count), 32'd1);
        for (int i = 0; i < 5; i++) push_op(7'h33, 3'd4, 7'h01, 6'(21 + i), 1'b1);
        check_eq("ill_sat", 32'(illegal_count), 32'd3);
        repeat (2) idle(1'b1);

        // SRAI push with simultaneous pop at q_count=2
        push_op(7'h03, 3'd2, 7'h00, 6'd30, 1'b0);
        push_op(7'h23, 3'd1, 7'h00, 6'd31, 1'b0);
        push_op(7'h13, 3'd5, 7'h20, 6'd32, 1'b1);
        check_eq("srai_cnt", 32'(q_count), 32'd2);
        idle(1'b1);
        check_eq("srai_sel", 32'(dec_unit_sel), 32'h04);
        check_eq("srai_ctrl", 32'(dec_ctrl), 32'd3);
        check_eq("srai_imm", 32'(dec_use_imm), 32'd1);
        idle(1'b1);

        // flush beats a same-cycle push and pop
        push_op(7'h63, 3'd0, 7'h00, 6'd40, 1'b0);
        push_op(7'h6F, 3'd0, 7'h00, 6'd41, 1'b0);
        push_op(7'h67, 3'd0, 7'h00, 6'd42, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 7'h63, 3'd2, 7'h00, 6'd43, 1'b1);
        check_eq("flush_cnt", 32'(q_count), 32'd0);
        check_eq("flush_valid", 32'(dec_valid), 32'd0);
        idle(1'b0);

        // reset mid-stream
        push_op(7'h23, 3'd0, 7'h00, 6'd50, 1'b0);
        push_op(7'h23, 3'd2, 7'h00, 6'd51, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 7'h7F, 3'd0, 7'h00, 6'd52, 1'b1);
        check_eq("rst_cnt", 32'(q_count), 32'd0);
        check_eq("rst_icnt", 32'(illegal_count), 32'd0);
        check_eq("rst_ready2", 32'(uop_ready_out), 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            op_r = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 2))
                0:       f7_r = 7'h00;
                1:       f7_r = 7'h20;
                default: f7_r = 7'($urandom);
            endcase
            cycle(1'b0, ($urandom_range(0, 19) == 0), 1'($urandom), op_r,
                  3'($urandom), f7_r, 6'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
